bitwise_pipe: RTL and testbench
===============================

# bitwise_pipe

Parametrised, registered successor to the 16-bit combinational NOT gate. It applies one of eight selectable bitwise operations to WIDTH-bit operand words and queues the results in a DEPTH-entry result FIFO. Both input and output use valid/ready handshakes. It sits between an operand source and a downstream ALU/consumer that may apply backpressure.

## Interface
- WIDTH, 16: operand/result width in bits; at least 1.
- DEPTH, 4: result FIFO entries; power of two, at least 2.
- CW, $clog2(DEPTH+1): derived width of `count`; not overridable.

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset; release is synchronous to clk upstream.
- in_valid  in  1  operand word valid.
- in_ready  out  1  block can accept an operand this cycle.
- op  in  3  operation select, sampled with a/b on accept.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; ignored for ops 0 and 7.
- out_valid  out  1  head result valid.
- out_ready  in  1  consumer takes head result this cycle.
- out  out  WIDTH  head result.
- zr  out  1  head result is all zeros.
- ng  out  1  head result MSB, out[WIDTH-1].
- count  out  CW  number of queued results, 0..DEPTH.

## Operation
- Op encoding:
  - 0: NOT a
  - 1: a AND b
  - 2: a OR b
  - 3: a XOR b
  - 4: NAND
  - 5: NOR
  - 6: XNOR
  - 7: PASS a
  - All 8 codes are legal.
- Accept: in_valid && in_ready at a rising edge.
  - The result is computed combinationally from a, b, op.
  - It is written at the write pointer together with its zr and ng flags.
  - The write pointer advances, modulo DEPTH.
- Pop: out_valid && out_ready at a rising edge.
  - The read pointer advances, modulo DEPTH.
- in_ready = (count != DEPTH). It is a pure function of registered count, with no combinational path from out_ready.
- out_valid = (count != 0).
- out, zr, ng:
  - Driven from the head entry when out_valid = 1.
  - Forced to 0 when out_valid = 0.
- count update:
  - +1 on accept only.
  - -1 on pop only.
  - Unchanged on simultaneous accept and pop, or when neither occurs.
- Full (count = DEPTH):
  - in_ready = 0; no accept, even if out_ready = 1 in the same cycle.
  - A pop that cycle frees a slot; in_ready rises the next cycle.
- Empty (count = 0):
  - No pop.
  - No bypass: an accepted word is never visible in the cycle it is accepted.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full/empty are determined from count, never from pointer compare.
- Data order: strict FIFO. Results leave in acceptance order.
- Input held while in_ready = 0 is not consumed; the source must keep in_valid asserted.

## Timing
- Reset (rst_n low, asynchronous):
  - count = 0, pointers = 0.
  - out_valid = 0, out = 0, zr = 0, ng = 0.
  - in_ready = 1.
  - Stored FIFO data is not reset; it is masked by count.
- Handshakes are ignored while rst_n is low.
- Reset asserted mid-stream discards all queued results immediately (asynchronously). No partial pop occurs.
- Latency: accepted at edge k, result at out with out_valid = 1 after edge k, i.e. in cycle k+1 when the FIFO was empty.
- Throughput: one accept and one pop per cycle sustained when 0 < count < DEPTH.
- Full-to-accept bubble: at least one cycle, by design (no bypass).
- out is stable while out_valid = 1 and out_ready = 0.

## Test plan
- Reset/idle (WIDTH=16, DEPTH=4): hold rst_n = 0 for 3 cycles, then release.
  - During reset and after release: count = 0, out_valid = 0, out = 16'h0000, in_ready = 1.
- All ops, a = 16'h00FF, b = 16'h0F0F, one per cycle, out_ready = 1. Required sequence one cycle after each accept, in order:
  - FF00 (ng = 1)
  - 000F
  - 0FFF
  - 0FF0
  - FFF0
  - F000
  - F00F
  - 00FF
- NOT-16 compatibility: op 0, a = 16'h00FF (low byte ones, high byte zeros) -> out = 16'hFF00. Also op 7 with a = 0 -> zr = 1, ng = 0.
- Fill/backpressure: out_ready = 0, push 5 words with a = 1..5, op 7.
  - First 4 accepted; count = 4; in_ready = 0; word 5 held.
  - Raise out_ready: pops 1,2,3,4.
  - Word 5 is accepted one cycle after the first pop.
  - Output order is 1,2,3,4,5.
- Simultaneous accept and pop at count = 2 for 10 cycles, a incrementing:
  - count stays 2.
  - Pointers wrap at least twice.
  - Outputs strictly in order, no loss or duplication.
- Mid-stream reset: count = 3, pulse rst_n low between clock edges.
  - out_valid and count go to 0 immediately, without waiting for a clock edge.
  - After release, the first new word emerges with the correct value.

Source files
------------

// File: rtl/bitwise_pipe.sv
// bitwise_pipe: registered bitwise unit. Each accepted operand word is reduced
// by one of eight bitwise operations and the result, with its zero and sign
// flags, is queued in a DEPTH-entry FIFO for a downstream consumer.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid && ready are both high. The sender holds its payload and valid until
// that edge. in_ready depends only on the registered count, so there is no
// combinational path from out_ready to in_ready. out_valid likewise depends
// only on the registered count.
module bitwise_pipe #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic [CW-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Each entry stores {zr, ng, result} so the flags are not recomputed at the head.
  logic [WIDTH+1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] res;
  logic [WIDTH+1:0] head;
  logic             acc;
  logic             pop;

  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign acc       = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem[rd_ptr];

  // Result of the selected bitwise operation on the current operands.
  always_comb begin
    res = '0;
    case (op)
      3'd0:    res = ~a;
      3'd1:    res = a & b;
      3'd2:    res = a | b;
      3'd3:    res = a ^ b;
      3'd4:    res = ~(a & b);
      3'd5:    res = ~(a | b);
      3'd6:    res = ~(a ^ b);
      default: res = a;
    endcase
  end

  // Head outputs, masked to zero whenever the queue is empty.
  always_comb begin
    out = '0;
    zr  = 1'b0;
    ng  = 1'b0;
    if (out_valid) begin
      out = head[WIDTH-1:0];
      ng  = head[WIDTH];
      zr  = head[WIDTH+1];
    end
  end

  // Result storage; not reset because count masks stale entries.
  always_ff @(posedge clk) begin
    if (acc) begin
      mem[wr_ptr] <= {(res == '0), res[WIDTH-1], res};
    end
  end

  // Pointers and occupancy; full/empty come from count only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({acc, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_bitwise_pipe.sv
// tb_bitwise_pipe: directed vectors for bitwise_pipe (WIDTH=16, DEPTH=4) with a
// pop-order scoreboard fed by the driver on every accepted word.
module tb_bitwise_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        zr;
  logic        ng;
  logic [2:0]  count;

  int n_checks;
  int n_fail;
  logic [15:0] exp_q[$];

  bitwise_pipe #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .zr(zr), .ng(ng), .count(count)
  );

  // Clock/reset block: 10 ns period, reset held low from time zero.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Driver: present one word (caller is just after a rising edge) and hold it
  // until accepted; the expected result then joins the scoreboard.
  task automatic send(input logic [2:0] o, input logic [15:0] va, input logic [15:0] vb,
                      input logic [15:0] exp);
    logic fire;
    fire = 1'b0;
    in_valid = 1'b1;
    op = o;
    a = va;
    b = vb;
    for (int i = 0; i < 20 && !fire; i++) begin
      @(negedge clk);
      fire = in_ready;
      @(posedge clk);
      #1;
    end
    check("send_accepted", {31'b0, fire}, 32'd1);
    if (fire) exp_q.push_back(exp);
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && count != 3'd0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_count", {29'b0, count}, 32'd0);
    check("drain_sb_empty", exp_q.size(), 32'd0);
  endtask

  // Scoreboard: each pop (sampled mid-cycle, i.e. the value seen at the next
  // rising edge) must match the oldest outstanding expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("pop_unexpected", {31'b0, out_valid}, 32'd0);
      else check("pop_order", {16'b0, out}, {16'b0, exp_q.pop_front()});
    end
  end

  initial begin
    logic [15:0] ops_exp [8];
    ops_exp[0] = 16'hFF00; ops_exp[1] = 16'h000F; ops_exp[2] = 16'h0FFF; ops_exp[3] = 16'h0FF0;
    ops_exp[4] = 16'hFFF0; ops_exp[5] = 16'hF000; ops_exp[6] = 16'hF00F; ops_exp[7] = 16'h00FF;
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = 3'd0;
    a = '0;
    b = '0;

    // Reset/idle.
    idle_cycles(3);
    check("rst_count", {29'b0, count}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out", {16'b0, out}, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_count", {29'b0, count}, 32'd0);
    check("idle_out_valid", {31'b0, out_valid}, 32'd0);
    check("idle_out", {16'b0, out}, 32'h0);
    check("idle_in_ready", {31'b0, in_ready}, 32'd1);

    // All eight ops, streaming with out_ready high.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(3'(i), 16'h00FF, 16'h0F0F, ops_exp[i]);
      check("op_valid", {31'b0, out_valid}, 32'd1);
      check("op_out", {16'b0, out}, {16'b0, ops_exp[i]});
      if (i == 0) begin
        check("not_ng", {31'b0, ng}, 32'd1);
        check("not_zr", {31'b0, zr}, 32'd0);
      end
    end
    send(3'd7, 16'h0000, 16'hFFFF, 16'h0000);
    check("pass0_zr", {31'b0, zr}, 32'd1);
    check("pass0_ng", {31'b0, ng}, 32'd0);
    check("pass0_valid", {31'b0, out_valid}, 32'd1);
    drain();

    // Fill and backpressure.
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      send(3'd7, 16'(k), 16'h0, 16'(k));
      check("fill_count", {29'b0, count}, 32'(k));
    end
    check("full_in_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b1;
    op = 3'd7;
    a = 16'd5;
    idle_cycles(1);
    check("full_hold_count", {29'b0, count}, 32'd4);
    check("full_head", {16'b0, out}, 32'd1);
    out_ready = 1'b1;
    idle_cycles(1);
    check("first_pop_count", {29'b0, count}, 32'd3);
    check("first_pop_in_ready", {31'b0, in_ready}, 32'd1);
    check("first_pop_head", {16'b0, out}, 32'd2);
    exp_q.push_back(16'd5);
    idle_cycles(1);
    in_valid = 1'b0;
    check("word5_count", {29'b0, count}, 32'd3);
    drain();

    // Simultaneous accept and pop at count = 2.
    out_ready = 1'b0;
    send(3'd7, 16'h0100, 16'h0, 16'h0100);
    send(3'd7, 16'h0101, 16'h0, 16'h0101);
    out_ready = 1'b1;
    for (int k = 2; k < 12; k++) begin
      send(3'd7, 16'h0100 + 16'(k), 16'h0, 16'h0100 + 16'(k));
      check("steady_count", {29'b0, count}, 32'd2);
    end
    drain();

    // Mid-stream asynchronous reset.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(3'd1, 16'hFFFF, 16'(k + 7), 16'(k + 7));
    check("pre_rst_count", {29'b0, count}, 32'd3);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_count", {29'b0, count}, 32'd0);
    check("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(3'd0, 16'hA5A5, 16'h0, 16'h5A5A);
    check("post_rst_out", {16'b0, out}, 32'h5A5A);
    check("post_rst_count", {29'b0, count}, 32'd1);
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
